iob_nesctrl_evq: RTL and testbench

- Downstream consumer of the two-pad NES controller interface. Takes the 16-bit per-pad button words plus a per-frame strobe, debounces the 8 button bits of each pad across frames, and turns committed press/release transitions into timestamped events.
- Events are queued in a first-word-fall-through FIFO drained by the CPU register file, with a level/overflow interrupt.

---
 rtl/iob_nesctrl_evq.sv | 188 ++++++++++++++++++
 tb/tb_iob_nesctrl_evq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_nesctrl_evq.sv
// -----------------------------------------------------------------------------
// iob_nesctrl_evq
// Debounces the 8 button bits of two NES pads across frames and converts
// committed press/release transitions into timestamped events, queued in a
// first-word-fall-through FIFO for the CPU.
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   frame_valid_i      one-cycle strobe: ctrl*_data_i hold a complete frame
//   ctrl1/2_data_i     pad words, bits 7:0 = buttons (1 = pressed)
//   stable1/2_o        debounced button state per pad
//   busy_o             event scan in progress (new frames are ignored)
//   evt_rd_i           pop FIFO head
//   evt_data_o         {stamp[7:0], pad, press, button[2:0]}
//   evt_valid_o        FIFO non-empty
//   evt_level_o        FIFO occupancy, 0..2^FIFO_AW
//   ovf_o, ovf_clr_i   sticky event-dropped flag and its clear
//   irq_o              registered evt_valid_o | ovf_o
// -----------------------------------------------------------------------------
module iob_nesctrl_evq #(
   parameter int FIFO_AW    = 4,
   parameter int DEB_FRAMES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_valid_i,
   input  logic [15:0]        ctrl1_data_i,
   input  logic [15:0]        ctrl2_data_i,
   output logic [7:0]         stable1_o,
   output logic [7:0]         stable2_o,
   output logic               busy_o,
   input  logic               evt_rd_i,
   output logic [12:0]        evt_data_o,
   output logic               evt_valid_o,
   output logic [FIFO_AW:0]   evt_level_o,
   output logic               ovf_o,
   input  logic               ovf_clr_i,
   output logic               irq_o
);

   localparam int               DEPTH = 1 << FIFO_AW;
   localparam logic [3:0]       DEB   = 4'(DEB_FRAMES);
   localparam logic [FIFO_AW:0] FULL  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t       state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   samp     [2];
   logic [7:0]   cand_q   [2];
   logic [7:0]   cand_d   [2];
   logic [3:0]   cnt_q    [2];
   logic [3:0]   cnt_d    [2];
   logic [7:0]   stable_q [2];
   logic [7:0]   diff_q   [2];
   logic [1:0]   commit;
   logic [7:0]   fc_q;
   logic [7:0]   stamp_q;
   logic         accept;

   // Upper pad bits carry nothing for this block.
   logic unused_hi;
   assign unused_hi = ^{ctrl1_data_i[15:8], ctrl2_data_i[15:8]};

   assign samp[0] = ctrl1_data_i[7:0];
   assign samp[1] = ctrl2_data_i[7:0];
   assign accept  = frame_valid_i && (state_q == IDLE);

   // Candidate/count update and commit decision for the current sample.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      commit = '0;
      for (int p = 0; p < 2; p++) begin
         if (samp[p] == cand_q[p]) begin
            cnt_d[p] = (cnt_q[p] >= DEB) ? DEB : cnt_q[p] + 4'd1;
         end else begin
            cand_d[p] = samp[p];
            cnt_d[p]  = 4'd1;
         end
         commit[p] = (cnt_d[p] == DEB) && (cand_d[p] != stable_q[p]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            cand_q[p]   <= '0;
            cnt_q[p]    <= '0;
            stable_q[p] <= '0;
            diff_q[p]   <= '0;
         end
         fc_q    <= '0;
         stamp_q <= '0;
      end else if (accept) begin
         for (int p = 0; p < 2; p++) begin
            cand_q[p] <= cand_d[p];
            cnt_q[p]  <= cnt_d[p];
            if (commit[p]) stable_q[p] <= cand_d[p];
            // Only committing pads contribute bits to the scan.
            diff_q[p] <= commit[p] ? (cand_d[p] ^ stable_q[p]) : 8'h00;
         end
         // Stamp is the counter value before this frame's increment.
         if (|commit) stamp_q <= fc_q;
         fc_q <= fc_q + 8'd1;
      end
   end

   // Scan FSM: fixed 16-cycle walk, pad1 bits 0..7 then pad2 bits 0..7.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = '0;
      case (state_q)
         IDLE: if (accept && (|commit)) state_d = SCAN;
         SCAN: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stable values are frozen during SCAN (frames are ignored), so they
   // hold the new value of every changed bit.
   logic        push_req;
   logic [12:0] push_data;
   assign push_req  = (state_q == SCAN) && diff_q[idx_q[3]][idx_q[2:0]];
   assign push_data = {stamp_q, idx_q[3], stable_q[idx_q[3]][idx_q[2:0]], idx_q[2:0]};

   // ---------------------------------------------------------------- FIFO
   logic [12:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               ovf_q, irq_q;
   logic               full, pop, push, drop;

   assign full = (count_q == FULL);
   assign pop  = evt_rd_i && (count_q != '0);
   // A push into a full FIFO succeeds when the head leaves in the same cycle.
   assign push = push_req && (!full || pop);
   assign drop = push_req && full && !pop;

   // NOTE: the storage array is deliberately not reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         // A drop in the same cycle as the clear keeps the flag set.
         if (drop)           ovf_q <= 1'b1;
         else if (ovf_clr_i) ovf_q <= 1'b0;
         irq_q <= (count_q != '0) || ovf_q;
      end
   end

   assign stable1_o   = stable_q[0];
   assign stable2_o   = stable_q[1];
   assign busy_o      = (state_q == SCAN);
   assign evt_valid_o = (count_q != '0);
   assign evt_data_o  = evt_valid_o ? mem[rd_ptr_q] : 13'h0000;
   assign evt_level_o = count_q;
   assign ovf_o       = ovf_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_iob_nesctrl_evq.sv
// -----------------------------------------------------------------------------
// tb_iob_nesctrl_evq
// Self-checking bench for iob_nesctrl_evq. A frame-level model (debounce
// rules, event list, bounded queue) predicts every event, level and flag.
// -----------------------------------------------------------------------------
module tb_iob_nesctrl_evq;

   localparam int AW  = 4;
   localparam int DEB = 2;
   localparam int CAP = 1 << AW;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_valid = 1'b0;
   logic [15:0] ctrl1 = '0, ctrl2 = '0;
   logic [7:0]  stable1, stable2;
   logic        busy;
   logic        evt_rd = 1'b0;
   logic [12:0] evt_data;
   logic        evt_valid;
   logic [AW:0] evt_level;
   logic        ovf;
   logic        ovf_clr = 1'b0;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   iob_nesctrl_evq #(.FIFO_AW(AW), .DEB_FRAMES(DEB)) dut (
      .clk(clk), .rst(rst), .frame_valid_i(frame_valid),
      .ctrl1_data_i(ctrl1), .ctrl2_data_i(ctrl2),
      .stable1_o(stable1), .stable2_o(stable2), .busy_o(busy),
      .evt_rd_i(evt_rd), .evt_data_o(evt_data), .evt_valid_o(evt_valid),
      .evt_level_o(evt_level), .ovf_o(ovf), .ovf_clr_i(ovf_clr), .irq_o(irq)
   );

   // ------------------------------------------------------------- model
   logic [7:0]  m_cand [2];
   logic [7:0]  m_stab [2];
   int          m_cnt  [2];
   int          m_fc;
   bit          m_ovf;
   logic [12:0] exp_q [$];
   logic [12:0] new_evts [$];

   function automatic void model_reset();
      for (int p = 0; p < 2; p++) begin
         m_cand[p] = '0; m_stab[p] = '0; m_cnt[p] = 0;
      end
      m_fc = 0; m_ovf = 0;
      exp_q.delete();
      new_evts.delete();
   endfunction

   // One accepted frame: debounce rules, then the changed bits in pad/bit order.
   function automatic void model_frame(logic [7:0] s1, logic [7:0] s2);
      logic [7:0] s [2];
      logic [7:0] old [2];
      s[0] = s1; s[1] = s2;
      new_evts.delete();
      for (int p = 0; p < 2; p++) begin
         old[p] = m_stab[p];
         if (s[p] == m_cand[p]) m_cnt[p] = (m_cnt[p] + 1 > DEB) ? DEB : m_cnt[p] + 1;
         else begin m_cand[p] = s[p]; m_cnt[p] = 1; end
         if (m_cnt[p] == DEB && m_cand[p] != m_stab[p]) m_stab[p] = m_cand[p];
      end
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < 8; b++)
            if (old[p][b] != m_stab[p][b])
               new_evts.push_back(13'(m_fc * 32 + p * 16 + int'(m_stab[p][b]) * 8 + b));
      m_fc = (m_fc + 1) % 256;
   endfunction

   function automatic void model_push(logic [12:0] e);
      if (exp_q.size() < CAP) exp_q.push_back(e);
      else m_ovf = 1;
   endfunction

   // --------------------------------------------------------- helpers
   task automatic do_reset();
      rst = 1'b0; frame_valid = 1'b0; evt_rd = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   // Drive one frame (random upper bytes), update the model, let any scan finish.
   task automatic send_frame(logic [7:0] s1, logic [7:0] s2);
      @(negedge clk);
      frame_valid = 1'b1;
      ctrl1 = {8'($urandom), s1};
      ctrl2 = {8'($urandom), s2};
      @(negedge clk);
      frame_valid = 1'b0;
      model_frame(s1, s2);
      foreach (new_evts[i]) model_push(new_evts[i]);
      repeat (20) @(negedge clk);
      n_checks++;
      if (stable1 !== m_stab[0]) begin
         n_fail++; $display("FAIL stable1: got %h expected %h", stable1, m_stab[0]);
      end
      n_checks++;
      if (stable2 !== m_stab[1]) begin
         n_fail++; $display("FAIL stable2: got %h expected %h", stable2, m_stab[1]);
      end
   endtask

   // Compare flags/level, then pop every expected event in order.
   task automatic drain(string tag);
      n_checks++;
      if (evt_level !== (AW + 1)'(exp_q.size())) begin
         n_fail++; $display("FAIL %s level: got %0d expected %0d", tag, evt_level, exp_q.size());
      end
      n_checks++;
      if (ovf !== m_ovf) begin
         n_fail++; $display("FAIL %s ovf: got %b expected %b", tag, ovf, m_ovf);
      end
      n_checks++;
      if (irq !== ((exp_q.size() != 0) || m_ovf)) begin
         n_fail++; $display("FAIL %s irq: got %b expected %b", tag, irq, (exp_q.size() != 0) || m_ovf);
      end
      while (exp_q.size() != 0) begin
         n_checks++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s event: got valid=%b data=%h expected data=%h", tag, evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         evt_rd = 1'b1;
         @(negedge clk);
         evt_rd = 1'b0;
      end
      n_checks++;
      if (evt_valid !== 1'b0 || evt_level !== '0) begin
         n_fail++; $display("FAIL %s empty: got valid=%b level=%0d expected 0/0", tag, evt_valid, evt_level);
      end
   endtask

   // ----------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({stable1, stable2, busy, evt_data, evt_valid, evt_level, ovf, irq} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got st1=%h st2=%h busy=%b data=%h valid=%b lvl=%0d ovf=%b irq=%b expected all 0",
                  stable1, stable2, busy, evt_data, evt_valid, evt_level, ovf, irq);
      end
      do_reset();
   endtask

   task automatic test_noop();
      do_reset();
      repeat (3) send_frame(8'h00, 8'h00);
      drain("noop");
      send_frame(8'h01, 8'h00);
      send_frame(8'h01, 8'h00);
      // Counter reached 3 after the idle frames, so this press carries stamp 4.
      n_checks++;
      if (evt_data !== 13'h088) begin
         n_fail++; $display("FAIL noop_stamp: got %h expected 088", evt_data);
      end
      drain("noop_press");
   endtask

   task automatic test_press_release();
      do_reset();
      send_frame(8'h01, 8'h00);
      send_frame(8'h01, 8'h00);
      n_checks++;
      if (evt_data !== 13'h028) begin
         n_fail++; $display("FAIL press_data: got %h expected 028", evt_data);
      end
      drain("press");
      send_frame(8'h00, 8'h00);
      send_frame(8'h00, 8'h00);
      n_checks++;
      if (evt_data !== 13'h060) begin
         n_fail++; $display("FAIL release_data: got %h expected 060", evt_data);
      end
      drain("release");
   endtask

   task automatic test_bounce();
      do_reset();
      send_frame(8'h00, 8'h80);
      send_frame(8'h00, 8'h00);
      send_frame(8'h00, 8'h80);
      send_frame(8'h00, 8'h80);
      n_checks++;
      if (evt_level !== 5'd1 || evt_data !== 13'h07F) begin
         n_fail++; $display("FAIL bounce: got level=%0d data=%h expected 1/07f", evt_level, evt_data);
      end
      drain("bounce");
   endtask

   task automatic test_multibit();
      int busy_cycles = 0;
      do_reset();
      send_frame(8'hFF, 8'hFF);
      @(negedge clk);
      frame_valid = 1'b1; ctrl1 = 16'h00FF; ctrl2 = 16'hA5FF;
      @(negedge clk);
      frame_valid = 1'b0;
      model_frame(8'hFF, 8'hFF);
      foreach (new_evts[i]) model_push(new_evts[i]);
      for (int i = 0; i < 24; i++) begin
         if (busy === 1'b1) busy_cycles++;
         if (i == 5) begin
            // Strobe mid-scan with different data: must be ignored entirely.
            frame_valid = 1'b1; ctrl1 = 16'h0000; ctrl2 = 16'h0000;
         end else frame_valid = 1'b0;
         @(negedge clk);
      end
      n_checks++;
      if (busy_cycles != 16) begin
         n_fail++; $display("FAIL busy_len: got %0d expected 16", busy_cycles);
      end
      drain("multibit");
      send_frame(8'h00, 8'h00);
      send_frame(8'h00, 8'h00);
      drain("multibit_release");
   endtask

   task automatic test_overflow();
      do_reset();
      send_frame(8'hFF, 8'hFF);
      send_frame(8'hFF, 8'hFF);
      send_frame(8'h00, 8'h00);
      send_frame(8'h00, 8'h00);
      n_checks++;
      if (evt_level !== 5'd16 || ovf !== 1'b1 || irq !== 1'b1) begin
         n_fail++; $display("FAIL ovf_state: got level=%0d ovf=%b irq=%b expected 16/1/1", evt_level, ovf, irq);
      end
      send_frame(8'hFF, 8'hFF);
      // Commit frame with a pop aligned to the first scan push.
      @(negedge clk);
      frame_valid = 1'b1; ctrl1 = 16'h33FF; ctrl2 = 16'h00FF;
      @(negedge clk);
      frame_valid = 1'b0; evt_rd = 1'b1;
      @(negedge clk);
      evt_rd = 1'b0;
      model_frame(8'hFF, 8'hFF);
      void'(exp_q.pop_front());
      foreach (new_evts[i]) model_push(new_evts[i]);
      n_checks++;
      if (evt_level !== 5'd16) begin
         n_fail++; $display("FAIL full_push_pop: got level=%0d expected 16", evt_level);
      end
      repeat (20) @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      m_ovf = 0;
      @(negedge clk);
      drain("overflow");
   endtask

   task automatic test_async_reset();
      do_reset();
      send_frame(8'hFF, 8'hFF);
      @(negedge clk);
      frame_valid = 1'b1; ctrl1 = 16'h00FF; ctrl2 = 16'h00FF;
      @(negedge clk);
      frame_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL midscan_busy: got %b expected 1", busy);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({stable1, stable2, busy, evt_data, evt_valid, evt_level, ovf, irq} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got st1=%h st2=%h busy=%b valid=%b lvl=%0d expected all 0",
                  stable1, stable2, busy, evt_valid, evt_level);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      send_frame(8'hFF, 8'hFF);
      drain("post_reset_first");
      send_frame(8'hFF, 8'hFF);
      drain("post_reset_second");
   endtask

   task automatic test_random();
      logic [7:0] lo [2];
      logic [7:0] pick;
      do_reset();
      lo[0] = '0; lo[1] = '0;
      for (int n = 0; n < 60; n++) begin
         for (int p = 0; p < 2; p++) begin
            case ($urandom_range(0, 3))
               0:       pick = 8'h00;
               1:       pick = 8'h01 << $urandom_range(0, 7);
               2:       pick = 8'($urandom);
               default: pick = 8'hFF;
            endcase
            if ($urandom_range(0, 9) < 4) lo[p] = pick;
         end
         send_frame(lo[0], lo[1]);
         drain("random");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_noop();
      test_press_release();
      test_bounce();
      test_multibit();
      test_overflow();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
